// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte FIFO plus transmit sequencer sitting between the command parser's
// response output and uart_tx. The parser may burst several reply bytes in
// consecutive cycles. This block buffers them and hands them to uart_tx one at
// a time. It also reports fill level and a sticky overflow flag back to the
// parser.
//
// Optional build macro: TX_FIFO_STATS_EN
//   When defined, the block adds o_tx_count (bytes completed, wrapping) and
//   o_drop_count (writes dropped, saturating). When not defined, those ports
//   and counters do not exist.
//
// Handshake semantics (both sides):
//   Parser -> FIFO : i_wr_dv is a one-cycle strobe that qualifies i_wr_byte.
//                    There is no ready. The parser is expected to watch
//                    o_full. A write that arrives while full, with no pop in
//                    the same cycle, is dropped and sets o_overflow.
//   FIFO -> uart_tx: o_tx_dv is a one-cycle start strobe. It is only issued
//                    from IDLE with i_tx_active low. o_tx_byte is loaded on
//                    the pop and stays stable until the next pop, so it covers
//                    the whole o_tx_dv .. i_tx_done window. i_tx_done is
//                    honoured only in WAIT_DONE and is ignored everywhere else.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_dv,
    input  logic [7:0]        i_wr_byte,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
`ifdef TX_FIFO_STATS_EN
    output logic [15:0]       o_tx_count,
    output logic [7:0]        o_drop_count,
`endif
    input  logic              i_tx_active,
    input  logic              i_tx_done
);

    // Occupancy value that means "full", sized to the counter.
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    // Storage and bookkeeping registers
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic [7:0]        r_tx_byte;
    state_t            r_state;

    // Combinational control
    state_t            w_next_state;
    logic              w_pop;
    logic              w_tx_dv;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_accept;
    logic              w_wr_drop;
    logic              w_done_accept;

    // Level flags come straight from the registered counter, so there is no
    // path from i_wr_dv to o_full / o_empty / o_count.
    assign w_full  = (r_count == FULL_LEVEL);
    assign w_empty = (r_count == '0);

    // A write into a full FIFO still fits if the sequencer pops in the same
    // cycle. The slot being read is the one the write pointer points at, so
    // the new byte lands at the tail exactly where it belongs.
    assign w_wr_accept   = i_wr_dv && (!w_full || w_pop);
    assign w_wr_drop     = i_wr_dv && w_full && !w_pop;
    assign w_done_accept = (r_state == ST_WAIT_DONE) && i_tx_done;

    // Next-state and strobe decode for the transmit sequencer
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_tx_dv      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !i_tx_active) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                w_tx_dv      = 1'b1;
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                // One dead cycle lets uart_tx leave its cleanup state before
                // the next start strobe.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset abandons any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte storage; contents need no reset because the counter qualifies them
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= i_wr_byte;
        end
    end

    // Write pointer advances on every accepted write and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every pop and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy counter; a simultaneous write and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_wr_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Output byte register; loads only on a pop so it is stable for uart_tx
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_byte <= 8'h00;
        end else if (w_pop) begin
            r_tx_byte <= r_mem[r_rd_ptr];
        end
    end

`ifdef TX_FIFO_STATS_EN
    logic [15:0] r_tx_count;
    logic [7:0]  r_drop_count;

    // Completed-byte counter; wraps from 16'hFFFF to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_count <= '0;
        end else if (w_done_accept) begin
            r_tx_count <= r_tx_count + 1'b1;
        end
    end

    // Dropped-write counter; saturates at 8'hFF
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= '0;
        end else if (w_wr_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign o_tx_count   = r_tx_count;
    assign o_drop_count = r_drop_count;
`else
    // Without the statistics counters the completion qualifier has no user.
    logic w_unused_done;
    assign w_unused_done = w_done_accept;
`endif

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx_dv    = w_tx_dv;
    assign o_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo (DEPTH=16). A small behavioural uart_tx
// model answers o_tx_dv with i_tx_active and a one-cycle i_tx_done. A negedge
// monitor scores every o_tx_dv against the expected byte queue and checks
// pulse width, latency and the done-to-start spacing.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int UART_BUSY = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_wr_dv = 1'b0;
  logic [7:0]        i_wr_byte = 8'h00;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              o_tx_dv;
  logic [7:0]        o_tx_byte;
  logic              i_tx_active;
  logic              i_tx_done = 1'b0;
`ifdef TX_FIFO_STATS_EN
  logic [15:0]       o_tx_count;
  logic [7:0]        o_drop_count;
`endif

  // uart_tx model busy flag, and a test-controlled hold that fakes a busy line
  logic uart_busy = 1'b0;
  logic hold      = 1'b0;
  assign i_tx_active = uart_busy | hold;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_dv     (i_wr_dv),
    .i_wr_byte   (i_wr_byte),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_tx_dv     (o_tx_dv),
    .o_tx_byte   (o_tx_byte),
`ifdef TX_FIFO_STATS_EN
    .o_tx_count  (o_tx_count),
    .o_drop_count(o_drop_count),
`endif
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int n_checks   = 0;
  int n_pass     = 0;
  int ncyc       = 0;
  int wr_ncyc    = 0;
  int done_ncyc  = 0;
  int dv_count   = 0;
  int done_total = 0;
  int peak       = 0;
  bit lat_en     = 1'b0;
  bit gap_en     = 1'b0;
  logic prev_dv  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  // Waits until the uart model has completed 'target' bytes in total, then
  // lets the sequencer settle back in IDLE.
  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_total < target && k < budget) begin
      step();
      k++;
    end
    check_eq("done_timeout", 32'(done_total >= target), 1);
    repeat (4) step();
  endtask

  // ---------------------------------------------------------------------------
  // uart_tx model: start on o_tx_dv, busy for UART_BUSY cycles, then done
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx_dv === 1'b1) begin
        @(posedge clk);
        #1 uart_busy = 1'b1;
        repeat (UART_BUSY - 1) @(posedge clk);
        #1;
        uart_busy = 1'b0;
        i_tx_done = 1'b1;
        done_total++;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: samples on the falling edge, scores every start strobe
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (i_wr_dv) wr_ncyc = ncyc;
      if (i_tx_done) done_ncyc = ncyc;
      if (int'(o_count) > peak) peak = int'(o_count);
      if (o_tx_dv === 1'b1) begin
        dv_count++;
        check_eq("dv_width", 32'(prev_dv), 0);
        check_eq("dv_while_active", 32'(i_tx_active), 0);
        if (lat_en) check_eq("wr_to_dv_latency", 32'(ncyc - wr_ncyc), 2);
        if (gap_en) check_eq("done_to_dv_gap", 32'(ncyc - done_ncyc), 3);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_tx", 32'(o_tx_byte), 32'hFFFF_FFFF);
        end else begin
          check_eq("tx_byte", 32'(o_tx_byte), 32'(exp_q.pop_front()));
        end
      end
      prev_dv = o_tx_dv;
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  int base_dv;
  int k;
`ifdef TX_FIFO_STATS_EN
  logic [15:0] base_tx;
`endif

  initial begin
    // Reset and idle
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_empty", 32'(o_empty), 1);
    check_eq("rst_full", 32'(o_full), 0);
    check_eq("rst_count", 32'(o_count), 0);
    check_eq("rst_overflow", 32'(o_overflow), 0);
    check_eq("rst_tx_dv", 32'(o_tx_dv), 0);
    check_eq("rst_tx_byte", 32'(o_tx_byte), 0);
`ifdef TX_FIFO_STATS_EN
    check_eq("rst_tx_count", 32'(o_tx_count), 0);
    check_eq("rst_drop_count", 32'(o_drop_count), 0);
`endif
    repeat (20) step();
    check_eq("idle_dv_count", 32'(dv_count), 0);
    check_eq("idle_empty", 32'(o_empty), 1);
    check_eq("idle_overflow", 32'(o_overflow), 0);

    // Single byte: start strobe two cycles after the write strobe
    lat_en = 1'b1;
    exp_q.push_back(8'h4F);
    i_wr_dv = 1'b1;
    i_wr_byte = 8'h4F;
    step();
    i_wr_dv = 1'b0;
    check_eq("single_count_after_wr", 32'(o_count), 1);
    wait_done(1, 100);
    lat_en = 1'b0;
    check_eq("single_dv_count", 32'(dv_count), 1);
    check_eq("single_empty", 32'(o_empty), 1);
    check_eq("single_tx_byte_held", 32'(o_tx_byte), 32'h4F);

    // Burst "OK\r\n" written while the line is busy, then released
    peak = 0;
    hold = 1'b1;
    foreach (exp_q[i]) check_eq("burst_q_empty", 1, 0);
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    for (int i = 0; i < 4; i++) begin
      i_wr_dv = 1'b1;
      i_wr_byte = exp_q[i];
      step();
    end
    i_wr_dv = 1'b0;
    check_eq("burst_count_peak", 32'(o_count), 4);
    hold = 1'b0;
    step();
    check_eq("burst_first_dv", 32'(o_tx_dv), 1);
    check_eq("burst_count_after_pop", 32'(o_count), 3);
    @(negedge clk);
    #1 gap_en = 1'b1;
    wait_done(5, 300);
    gap_en = 1'b0;
    check_eq("burst_peak_seen", 32'(peak), 4);
    check_eq("burst_q_drained", 32'(exp_q.size()), 0);
    check_eq("burst_empty", 32'(o_empty), 1);

    // Overflow: 17 writes into a held 16-deep FIFO
`ifdef TX_FIFO_STATS_EN
    base_tx = o_tx_count;
`endif
    hold = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      i_wr_dv = 1'b1;
      i_wr_byte = 8'(8'h10 + i);
      if (i < DEPTH) exp_q.push_back(8'(8'h10 + i));
      if (i == DEPTH) begin
        check_eq("ovf_full_at_16", 32'(o_full), 1);
        check_eq("ovf_count_at_16", 32'(o_count), 16);
        check_eq("ovf_flag_before_17th", 32'(o_overflow), 0);
      end
      step();
    end
    i_wr_dv = 1'b0;
    check_eq("ovf_flag_set", 32'(o_overflow), 1);
    check_eq("ovf_count_unchanged", 32'(o_count), 16);
    hold = 1'b0;
    wait_done(21, 1000);
    check_eq("ovf_q_drained", 32'(exp_q.size()), 0);
    check_eq("ovf_flag_sticky", 32'(o_overflow), 1);
    check_eq("ovf_empty_after_drain", 32'(o_empty), 1);
`ifdef TX_FIFO_STATS_EN
    check_eq("ovf_drop_count", 32'(o_drop_count), 1);
    check_eq("ovf_tx_count_delta", 32'(16'(o_tx_count - base_tx)), 16);
`endif

    // Full FIFO with a write landing on the pop cycle
    pulse_reset();
    check_eq("pop_wr_rst_overflow", 32'(o_overflow), 0);
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      i_wr_dv = 1'b1;
      i_wr_byte = 8'(8'h30 + i);
      exp_q.push_back(8'(8'h30 + i));
      step();
    end
    check_eq("pop_wr_full", 32'(o_full), 1);
    hold = 1'b0;
    i_wr_dv = 1'b1;
    i_wr_byte = 8'h99;
    exp_q.push_back(8'h99);
    step();
    i_wr_dv = 1'b0;
    check_eq("pop_wr_dv", 32'(o_tx_dv), 1);
    check_eq("pop_wr_count", 32'(o_count), 16);
    check_eq("pop_wr_overflow", 32'(o_overflow), 0);
    wait_done(38, 1000);
    check_eq("pop_wr_q_drained", 32'(exp_q.size()), 0);
    check_eq("pop_wr_empty", 32'(o_empty), 1);

    // Reset during WAIT_DONE with five bytes still queued
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_wr_dv = 1'b1;
      i_wr_byte = 8'(8'hA0 + i);
      exp_q.push_back(8'(8'hA0 + i));
      step();
    end
    i_wr_dv = 1'b0;
    hold = 1'b0;
    k = 0;
    while (!uart_busy && k < 50) begin
      step();
      k++;
    end
    check_eq("mid_rst_busy_seen", 32'(uart_busy), 1);
    check_eq("mid_rst_queued", 32'(o_count), 5);
    pulse_reset();
    base_dv = dv_count;
    check_eq("mid_rst_count", 32'(o_count), 0);
    check_eq("mid_rst_empty", 32'(o_empty), 1);
    check_eq("mid_rst_full", 32'(o_full), 0);
    check_eq("mid_rst_overflow", 32'(o_overflow), 0);
    check_eq("mid_rst_tx_dv", 32'(o_tx_dv), 0);
    check_eq("mid_rst_tx_byte", 32'(o_tx_byte), 0);
    wait_done(39, 100);
    repeat (10) step();
    check_eq("mid_rst_no_dv", 32'(dv_count - base_dv), 0);
    check_eq("mid_rst_count_late", 32'(o_count), 0);
    check_eq("mid_rst_tx_byte_late", 32'(o_tx_byte), 0);
`ifdef TX_FIFO_STATS_EN
    check_eq("mid_rst_tx_count", 32'(o_tx_count), 0);
    check_eq("mid_rst_drop_count", 32'(o_drop_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
